// File: rtl/bus_src_arbiter_pkg.sv
// Shared types and sizes for the bus source arbiter.
package bus_src_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 8;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a source index.
  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_src_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches from (last+1) mod 4 upward and
// returns the first source whose req and mask bits are both set. The source
// named by last is visited last, so it only wins when it is the sole candidate.
module rr_pick4
  import bus_src_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  input  logic [NUM_SRC-1:0] mask,
  output logic               found,
  output logic [SEL_W-1:0]   winner
);

  // Walk the four candidates in rotated order, first hit wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx] && mask[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/bus_src_arbiter.sv
// Four-source round-robin bus arbiter with a shared 8-bit 4:1 data mux.
// Optional grant locking is compiled in when BUS_ARB_LOCK_EN is defined.
//
// Handshake: dvalid is req[sel] while in GRANT; a transfer completes on a
// rising edge where dvalid && dready. dvalid may drop without a transfer
// (abort), which releases the grant without updating the round-robin pointer.
module bus_src_arbiter
  import bus_src_arbiter_pkg::*;
#(
  parameter logic [SEL_W-1:0] IDLE_SEL = 2'b00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [DATA_W-1:0]  din0,
  input  logic [DATA_W-1:0]  din1,
  input  logic [DATA_W-1:0]  din2,
  input  logic [DATA_W-1:0]  din3,
`ifdef BUS_ARB_LOCK_EN
  input  logic [NUM_SRC-1:0] lock,
`endif
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  dout,
  output logic               dvalid,
  input  logic               dready,
  output logic               busy,
  output logic               state_dbg
);

  state_t             state;
  logic [SEL_W-1:0]   last;
  logic [SEL_W-1:0]   pick_last;
  logic [NUM_SRC-1:0] pick_mask;
  logic               found;
  logic [SEL_W-1:0]   winner;
  logic               lock_hold;
  logic [DATA_W-1:0]  mux_out;

`ifdef BUS_ARB_LOCK_EN
  assign lock_hold = lock[sel];
`else
  assign lock_hold = 1'b0;
`endif

  // Rearbitration setup: after a transfer the current owner becomes "last"
  // (lowest priority); on abort the owner is masked out and last is kept.
  always_comb begin
    pick_last = last;
    pick_mask = '1;
    if (state == ST_GRANT) begin
      if (req[sel]) pick_last = sel;
      else          pick_mask[sel] = 1'b0;
    end
  end

  rr_pick4 u_pick (
    .req    (req),
    .last   (pick_last),
    .mask   (pick_mask),
    .found  (found),
    .winner (winner)
  );

  // Arbiter FSM with registered grant/sel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      sel   <= IDLE_SEL;
      last  <= 2'd3;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_GRANT;
            grant <= onehot(winner);
            sel   <= winner;
          end
        end
        ST_GRANT: begin
          if (req[sel]) begin
            // Owner still requesting: only move on a completed transfer.
            if (dready && !lock_hold) begin
              last  <= sel;
              grant <= onehot(winner);
              sel   <= winner;
            end
          end else if (found) begin
            grant <= onehot(winner);
            sel   <= winner;
          end else begin
            state <= ST_IDLE;
            grant <= '0;
            sel   <= IDLE_SEL;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          sel   <= IDLE_SEL;
        end
      endcase
    end
  end

  // Plain 4:1 source mux driven by the registered select.
  always_comb begin
    case (sel)
      2'd0:    mux_out = din0;
      2'd1:    mux_out = din1;
      2'd2:    mux_out = din2;
      default: mux_out = din3;
    endcase
  end

  assign busy      = (state == ST_GRANT);
  assign dout      = busy ? mux_out : '0;
  assign dvalid    = busy & req[sel];
  assign state_dbg = state;

endmodule

// File: doc/bus_src_arbiter.md
BUS_SRC_ARBITER -- requirements
Module: bus_src_arbiter

Interface
REQ-001 Parameter IDLE_SEL, default 2'b00: value driven on sel while no requester is granted.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-source transfer request; bit i belongs to source i.
REQ-005 din0..din3  input  8 each  source data; each source SHALL hold its data stable while its req is high.
REQ-006 lock  input  4  per-source grant-hold request; present only with BUS_ARB_LOCK_EN.
REQ-007 grant  output  4  one-hot grant, or all-zero when idle.
REQ-008 sel  output  2  index of the granted source; drives the shared 8-bit 4:1 source mux select.
REQ-009 dout  output  8  data of the granted source (din[sel]); 8'h00 when idle.
REQ-010 dvalid  output  1  dout valid toward the consumer.
REQ-011 dready  input  1  consumer accepts dout.
REQ-012 busy  output  1  high in the GRANT state.

Function
REQ-013 The FSM SHALL have two states: IDLE and GRANT.
REQ-014 IDLE with req != 0: pick a winner round-robin, starting at (last+1) mod 4. Next cycle: GRANT, grant = onehot(winner), sel = winner.
REQ-015 IDLE with req == 0: remain in IDLE.
REQ-016 In GRANT, dvalid SHALL equal req[sel] (combinational); dout SHALL equal din[sel].
REQ-017 Handshake: dvalid && dready on a rising edge completes one transfer.
REQ-018 On a handshake, last <= sel, then rearbitrate in the same cycle using the req value of that cycle:
  - any req high: GRANT to the new winner next cycle, with no idle bubble;
  - req == 0: go to IDLE.
REQ-019 The current winner SHALL have lowest priority at rearbitration; it is regranted only if it is the sole requester.
REQ-020 Abort: in GRANT with req[sel] low, there is no transfer. last stays unchanged; rearbitrate as in REQ-018, excluding the aborting source.
REQ-021 grant, sel, dout and busy SHALL be glitch-free registered or registered-select derived. Arbitration latency from IDLE is exactly 1 cycle.
REQ-022 With dready held low, grant SHALL hold indefinitely. There is no timeout.
REQ-023 A req change on a non-granted source during GRANT SHALL have no effect until the next rearbitration.

Reset
REQ-024 While rst_n is low, asynchronously:
  - state IDLE, grant 4'b0000, sel IDLE_SEL;
  - dout 8'h00, dvalid 0, busy 0;
  - last 2'd3, so source 0 has first priority.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer. No handshake is reported after rst_n rises.
REQ-026 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro BUS_ARB_LOCK_EN defined:
  - the lock port exists;
  - on a handshake with lock[sel] and req[sel] both high, the same source SHALL be regranted, overriding round-robin;
  - last SHALL update only when the lock is released.
REQ-028 Macro BUS_ARB_LOCK_EN undefined: the lock port is absent and behaviour is pure round-robin per REQ-018/019.

Structure
REQ-029 The shared package SHALL hold:
  - the state enum (IDLE, GRANT);
  - NUM_SRC = 4, DATA_W = 8, SEL_W = 2.
REQ-030 Sub-module rr_pick4 (combinational) SHALL take req[3:0], last[1:0] and a mask[3:0], and return a found flag and a winner index.
REQ-031 The data path SHALL be a plain 4:1 case mux on sel inside the block.

Verification
REQ-032 Single source: after reset, req=4'b0100, din2=8'hA5, dready=1.
  - Cycle 1: grant=4'b0100, sel=2, dout=8'hA5, dvalid=1.
  - After the handshake with req dropped: IDLE, grant=0.
REQ-033 Round-robin: req=4'b1111 held, dready=1 continuously.
  - Grant order SHALL be 0,1,2,3,0, one per cycle, with no bubble.
REQ-034 Backpressure: source 1 granted, dready=0 for 5 cycles.
  - grant=4'b0010 and dout stable for all 5 cycles.
  - req 3 raised meanwhile is granted only after dready=1.
REQ-035 Abort: source 3 granted, req[3] dropped with dready=0 and req[0] high.
  - dvalid=0 that cycle.
  - Next cycle grant=4'b0001; last remains unchanged.
REQ-036 Reset mid-transfer: rst_n pulled low during GRANT.
  - Outputs immediately go to grant=0, sel=IDLE_SEL, dvalid=0.
  - After release with req=4'b1111, source 0 wins first.
REQ-037 Lock (with BUS_ARB_LOCK_EN): source 2 has lock=1 and req=1 while req=4'b1111.
  - Three consecutive handshakes all go to source 2.
  - After lock drops, the next grant is source 3.
